// File: rtl/tetromino_stamper.sv
// tetromino_stamper: expands a tetromino command into 4 cells and draws, erases or collision-checks them in the playfield memory
module tetromino_stamper #(
  parameter int FIELD_W = 10,
  parameter int FIELD_H = 22
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iStart,
  input  logic [1:0]  iOp,
  input  logic [2:0]  iType,
  input  logic [1:0]  iRot,
  input  logic [4:0]  iX,
  input  logic [4:0]  iY,
  output logic        oBusy,
  output logic        oDone,
  output logic        oCollision,
  output logic [9:0]  oMemAddr,
  output logic        oMemWe,
  output logic [11:0] oMemWrData,
  input  logic [11:0] iMemRdData
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, CMP_LAST, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] k, op, rot, dx, dy;
  logic [2:0] typ;
  logic [4:0] ox, oy;
  logic [5:0] cx, cy;
  logic [11:0] colour;
  logic oob, prev_oob;
  // Rotation-0 offsets packed as {cell3,cell2,cell1,cell0}, each {dx,dy}; O keeps its cell order under rotation
  function automatic logic [3:0] cell_off(input logic [2:0] t, input logic [1:0] r, input logic [1:0] c);
    logic [15:0] tab;
    logic [1:0] x, y, b;
    case (t)
      3'd0:    tab = 16'h3210;
      3'd1:    tab = 16'h5140;
      3'd2:    tab = 16'h6210;
      3'd3:    tab = 16'h2654;
      3'd4:    tab = 16'h5184;
      3'd5:    tab = 16'h9540;
      3'd6:    tab = 16'h5840;
      default: tab = 16'h0000;
    endcase
    {x, y} = tab[{c, 2'b00} +: 4];
    b = (t == 3'd0) ? 2'd3 : 2'd2;
    for (int i = 0; i < 3; i++)
      if (i < int'(r) && t != 3'd1) {x, y} = {b - y, x};
    return {x, y};
  endfunction
  // Current cell geometry, bounds and colour from the latched command
  always_comb begin
    {dx, dy} = cell_off(typ, rot, k);
    cx = {1'b0, ox} + {4'b0, dx};
    cy = {1'b0, oy} + {4'b0, dy};
    oob = (typ == 3'd7) || (cx >= 6'(FIELD_W)) || (cy >= 6'(FIELD_H));
    colour = typ == 3'd0 ? 12'h0FF : typ == 3'd1 ? 12'hFF0 : typ == 3'd2 ? 12'hF80 :
             typ == 3'd3 ? 12'h00F : typ == 3'd4 ? 12'h0F0 : typ == 3'd5 ? 12'hF00 :
             typ == 3'd6 ? 12'hF0F : 12'h000;
  end
  // Next-state and memory-port outputs
  always_comb begin
    state_nx = state == IDLE     ? (iStart ? ((iOp == 2'd1 || iOp == 2'd2) ? WRITE : READ) : IDLE) :
               state == WRITE    ? (k == 2'd3 ? DONE : WRITE) :
               state == READ     ? (k == 2'd3 ? CMP_LAST : READ) :
               state == CMP_LAST ? DONE : IDLE;
    oBusy = state != IDLE;
    oDone = state == DONE;
    oMemWe = state == WRITE && !oob;
    oMemWrData = (oMemWe && op != 2'd2) ? colour : 12'h000;
    oMemAddr = (state == WRITE || state == READ) ? {cx[4:0], cy[4:0]} : 10'd0;
  end
  // State, cell index, command latch and collision accumulation; read data lags the address by one cycle
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
      k <= 2'd0;
      op <= 2'd0;
      typ <= 3'd0;
      rot <= 2'd0;
      ox <= 5'd0;
      oy <= 5'd0;
      prev_oob <= 1'b0;
      oCollision <= 1'b0;
    end else begin
      state <= state_nx;
      k <= (state == WRITE || state == READ) ? k + 2'd1 : 2'd0;
      prev_oob <= oob;
      if (state == IDLE && iStart) begin
        op <= iOp;
        typ <= iType;
        rot <= iRot;
        ox <= iX;
        oy <= iY;
        oCollision <= 1'b0;
      end else if ((state == READ && k != 2'd0) || state == CMP_LAST)
        oCollision <= oCollision | prev_oob | (|iMemRdData);
    end
  end
endmodule

// File: tb/tb_tetromino_stamper.sv
// tb_tetromino_stamper: randomized and directed checks of tetromino_stamper against a cell-level reference model
module tb_tetromino_stamper;
  logic iCLK = 1'b0, iRST_N = 1'b0, iStart = 1'b0;
  logic [1:0] iOp = 2'd0, iRot = 2'd0;
  logic [2:0] iType = 3'd0;
  logic [4:0] iX = 5'd0, iY = 5'd0;
  logic oBusy, oDone, oCollision, oMemWe;
  logic [9:0] oMemAddr;
  logic [11:0] oMemWrData;
  logic [11:0] iMemRdData = 12'h000;
  logic [11:0] sram [1024];
  logic [11:0] ref_mem [1024];
  int n_cmp = 0, n_bad = 0;
  bit exp_coll = 1'b0;
  int sdx [7][4] = '{'{0,0,0,0}, '{0,1,0,1}, '{0,0,0,1}, '{1,1,1,0}, '{1,2,0,1}, '{0,1,1,2}, '{0,1,2,1}};
  int sdy [7][4] = '{'{0,1,2,3}, '{0,0,1,1}, '{0,1,2,2}, '{0,1,2,2}, '{0,0,1,1}, '{0,0,1,1}, '{0,0,0,1}};
  int col [7] = '{'h0FF, 'hFF0, 'hF80, 'h00F, 'h0F0, 'hF00, 'hF0F};

  tetromino_stamper dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iStart(iStart), .iOp(iOp), .iType(iType), .iRot(iRot),
    .iX(iX), .iY(iY), .oBusy(oBusy), .oDone(oDone), .oCollision(oCollision),
    .oMemAddr(oMemAddr), .oMemWe(oMemWe), .oMemWrData(oMemWrData), .iMemRdData(iMemRdData)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) begin
    if (oMemWe) sram[oMemAddr] <= oMemWrData;
    iMemRdData <= sram[oMemAddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_rand();
    iOp = 2'($urandom); iType = 3'($urandom); iRot = 2'($urandom);
    iX = 5'($urandom); iY = 5'($urandom);
  endtask

  task automatic run_cmd(input int op, input int t, input int r, input int x, input int y, input bit spur);
    int cxs [4], cys [4], addr [4];
    bit oob [4];
    bit is_wr, coll;
    int lat, dx, dy, tmp;
    for (int c = 0; c < 4; c++) begin
      dx = (t < 7) ? sdx[t][c] : 0;
      dy = (t < 7) ? sdy[t][c] : 0;
      if (t != 1)
        for (int i = 0; i < r; i++) begin
          tmp = dx;
          dx = ((t == 0) ? 3 : 2) - dy;
          dy = tmp;
        end
      cxs[c] = x + dx;
      cys[c] = y + dy;
      oob[c] = (t == 7) || cxs[c] >= 10 || cys[c] >= 22;
      addr[c] = (cxs[c] % 32) * 32 + (cys[c] % 32);
    end
    is_wr = (op == 1 || op == 2);
    lat = is_wr ? 5 : 6;
    coll = 1'b0;
    for (int c = 0; c < 4; c++) coll = coll | oob[c] | (!oob[c] && ref_mem[addr[c]] != 0);
    chk("idle_busy", oBusy, 0);
    chk("idle_done", oDone, 0);
    chk("coll_hold", oCollision, exp_coll);
    iStart = 1'b1;
    iOp = 2'(op); iType = 3'(t); iRot = 2'(r); iX = 5'(x); iY = 5'(y);
    @(negedge iCLK);
    for (int c = 1; c <= lat; c++) begin
      iStart = spur && c == 3;
      drive_rand();
      chk("busy", oBusy, 1);
      chk("done", oDone, c == lat);
      if (c <= 4) begin
        if (t != 7) chk("addr", oMemAddr, addr[c-1]);
        chk("we", oMemWe, is_wr && !oob[c-1]);
        chk("wdata", oMemWrData, (is_wr && !oob[c-1] && op == 1) ? col[t] : 0);
      end else begin
        chk("we_idle", oMemWe, 0);
        chk("wdata_idle", oMemWrData, 0);
      end
      if (c == 1) chk("coll_clear", oCollision, 0);
      if (c == lat && !is_wr) chk("collision", oCollision, coll);
      @(negedge iCLK);
    end
    iStart = 1'b0;
    if (is_wr)
      for (int c = 0; c < 4; c++)
        if (!oob[c]) ref_mem[addr[c]] = (op == 2) ? 12'h000 : 12'(col[t]);
    exp_coll = is_wr ? 1'b0 : coll;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      sram[i] = 12'h000;
      ref_mem[i] = 12'h000;
    end
  endtask

  initial begin
    clear_mem();
    repeat (2) @(negedge iCLK);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    chk("rst_coll", oCollision, 0);
    chk("rst_we", oMemWe, 0);
    chk("rst_addr", oMemAddr, 0);
    chk("rst_wdata", oMemWrData, 0);
    iRST_N = 1'b1;
    @(negedge iCLK);
    iStart = 1'b1; iOp = 2'd1; iType = 3'd6; iRot = 2'd0; iX = 5'd0; iY = 5'd0;
    @(negedge iCLK);
    iStart = 1'b0;
    @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    chk("abort_we", oMemWe, 0);
    chk("abort_busy", oBusy, 0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge iCLK);
      chk("post_abort_we", oMemWe, 0);
      chk("post_abort_busy", oBusy, 0);
    end
    clear_mem();
    exp_coll = 1'b0;
    run_cmd(1, 0, 0, 4, 0, 0);
    sram[4*32+6] = 12'hF00;
    ref_mem[4*32+6] = 12'hF00;
    run_cmd(0, 6, 1, 3, 5, 0);
    chk("t3_hit", oCollision, 1);
    sram[4*32+6] = 12'h000;
    ref_mem[4*32+6] = 12'h000;
    run_cmd(0, 6, 1, 3, 5, 0);
    chk("t3_clear", oCollision, 0);
    run_cmd(0, 1, 0, 9, 3, 0);
    chk("t4_oob", oCollision, 1);
    run_cmd(1, 1, 0, 9, 3, 0);
    run_cmd(2, 5, 0, 0, 20, 1);
    run_cmd(0, 5, 0, 0, 20, 0);
    run_cmd(1, 7, 0, 2, 2, 0);
    run_cmd(0, 7, 0, 2, 2, 0);
    chk("t6_invalid", oCollision, 1);
    for (int i = 0; i < 1024; i++)
      if ($urandom_range(0, 7) == 0) begin
        sram[i] = 12'($urandom_range(1, 4095));
        ref_mem[i] = sram[i];
      end
    for (int n = 0; n < 300; n++) begin
      run_cmd($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 11),
              ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 23),
              $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge iCLK);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
